// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Rows and columns are both active-low on the GPIO side.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int ROW_N = 4;
  localparam int COL_N = 4;
  localparam logic [COL_N-1:0] COL_IDLE = 4'hF;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEB_PRESS,
    ST_HELD,
    ST_DEB_RELEASE
  } kp_state_t;

  // Index of the lowest-numbered row pulled low; 0 when none is low.
  function automatic logic [1:0] lowest_low_row(input logic [ROW_N-1:0] rows);
    lowest_low_row = 2'd0;
    for (int i = ROW_N - 1; i >= 0; i--) begin
      if (!rows[i]) lowest_low_row = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_4x4_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so
// idle pulled-up lines read as released.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: walks the columns, debounces one candidate key
// and hands accepted key codes to the consumer over a valid/ready handshake.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic [ROW_N-1:0] row_sense,
  output logic [COL_N-1:0] col_drive,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_down,
  output logic             overrun
);

  localparam int TICK_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [ROW_N-1:0]  w_rs;
  logic              w_sample;
  logic              w_cand_bit;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_event;
  logic [KEY_W-1:0]  w_event_code;

  kp_state_t         r_state;
  logic [TICK_W-1:0] r_tick;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_col_idx;
  logic [1:0]        r_cand_row;
  logic [1:0]        r_cand_col;
  logic              r_key_down;
  logic [KEY_W-1:0]  r_key_code;
  logic              r_key_valid;
  logic              r_overrun;

  sync_2ff #(.WIDTH(ROW_N)) u_row_sync (
    .i_clk (CLOCK_50),
    .i_rst (reset),
    .i_d   (row_sense),
    .o_q   (w_rs)
  );

  assign w_sample   = enable && (r_tick == TICK_LAST);
  assign w_cand_bit = w_rs[r_cand_row];
  assign w_cnt_inc  = r_cnt + CNT_ONE;

  // An event fires on the sample that completes press debouncing; with a
  // single-tick debounce the first sighting in SCAN already qualifies.
  always_comb begin
    w_event      = 1'b0;
    w_event_code = {r_cand_row, r_cand_col};
    if (w_sample) begin
      if (r_state == ST_SCAN && w_rs != COL_IDLE && DEBOUNCE_TICKS == 1) begin
        w_event      = 1'b1;
        w_event_code = {lowest_low_row(w_rs), r_col_idx};
      end else if (r_state == ST_DEB_PRESS && !w_cand_bit && w_cnt_inc == CNT_DONE) begin
        w_event      = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= ST_SCAN;
      r_tick     <= '0;
      r_cnt      <= '0;
      r_col_idx  <= 2'd0;
      r_cand_row <= 2'd0;
      r_cand_col <= 2'd0;
      r_key_down <= 1'b0;
    end else if (!enable) begin
      r_state    <= ST_SCAN;
      r_tick     <= '0;
      r_cnt      <= '0;
      r_col_idx  <= 2'd0;
      r_key_down <= 1'b0;
    end else begin
      r_tick <= w_sample ? '0 : r_tick + 1'b1;
      if (w_sample) begin
        case (r_state)
          ST_SCAN: begin
            if (w_rs == COL_IDLE) begin
              r_col_idx <= r_col_idx + 2'd1;
            end else begin
              r_cand_row <= lowest_low_row(w_rs);
              r_cand_col <= r_col_idx;
              r_cnt      <= CNT_ONE;
              if (DEBOUNCE_TICKS == 1) begin
                r_state    <= ST_HELD;
                r_key_down <= 1'b1;
              end else begin
                r_state    <= ST_DEB_PRESS;
              end
            end
          end
          ST_DEB_PRESS: begin
            if (!w_cand_bit) begin
              if (w_cnt_inc == CNT_DONE) begin
                r_state    <= ST_HELD;
                r_key_down <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state   <= ST_SCAN;
              r_col_idx <= r_col_idx + 2'd1;
            end
          end
          ST_HELD: begin
            if (w_cand_bit) begin
              if (DEBOUNCE_TICKS == 1) begin
                r_state    <= ST_SCAN;
                r_key_down <= 1'b0;
                r_col_idx  <= r_col_idx + 2'd1;
              end else begin
                r_cnt   <= CNT_ONE;
                r_state <= ST_DEB_RELEASE;
              end
            end
          end
          ST_DEB_RELEASE: begin
            if (w_cand_bit) begin
              if (w_cnt_inc == CNT_DONE) begin
                r_state    <= ST_SCAN;
                r_key_down <= 1'b0;
                r_col_idx  <= r_col_idx + 2'd1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= ST_HELD;
            end
          end
          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

  // A fresh event always wins; it only counts as an overrun when the
  // pending one was not being taken in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_event) begin
      r_key_code  <= w_event_code;
      r_key_valid <= 1'b1;
      if (r_key_valid && !key_ready) r_overrun <= 1'b1;
    end else if (r_key_valid && key_ready) begin
      r_key_valid <= 1'b0;
    end
  end

  assign col_drive = (enable && !reset) ? ~(COL_N'(1) << r_col_idx) : COL_IDLE;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Bench for keypad_scanner_4x4: a keypad matrix model drives the rows from
// the column drive; accepted key codes are scoreboarded against expectations.
module tb_keypad_scanner_4x4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  row_sense;
  logic [3:0]  col_drive;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_down;
  logic        overrun;

  logic [15:0] pressed;
  logic        rnd_rdy;
  int          sb[$];
  int          n_vec;
  int          n_mis;

  keypad_scanner_4x4 #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .enable    (enable),
    .row_sense (row_sense),
    .col_drive (col_drive),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column while that
  // column is driven low.
  always_comb begin
    row_sense = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_drive[c]) row_sense[r] = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_rdy) key_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_ready();
    key_ready = 1'b1;
    cyc();
    key_ready = 1'b0;
  endtask

  task automatic wait_down(input logic level, input string name);
    int n = 0;
    while (key_down !== level && n < 300) begin cyc(); n++; end
    chk(name, int'(key_down === level), 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (key_valid !== 1'b1 && n < 300) begin cyc(); n++; end
    chk(name, int'(key_valid === 1'b1), 1);
  endtask

  task automatic wait_col(input logic [3:0] pat, input string name);
    int n = 0;
    while (col_drive !== pat && n < 40) begin cyc(); n++; end
    chk(name, int'(col_drive), int'(pat));
  endtask

  // Monitor: every handshake completion must match the oldest expectation.
  always @(negedge clk) begin
    int e;
    if (!reset && key_valid && key_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_event", int'(key_code), -1);
      end else begin
        e = sb.pop_front();
        chk("sb_code", int'(key_code), e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int col, mask, lr;
    n_vec = 0; n_mis = 0;
    reset = 1'b1; enable = 1'b1; key_ready = 1'b0; pressed = '0; rnd_rdy = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_col", int'(col_drive), 'hF);
      chk("rst_valid", int'(key_valid), 0);
      chk("rst_down", int'(key_down), 0);
      chk("rst_code", int'(key_code), 0);
      chk("rst_ovr", int'(overrun), 0);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 17; i++) begin
      chk("scan_col", int'(col_drive), (~(1 << ((i / 4) % 4))) & 'hF);
      cyc();
    end

    // Key 9 (row2/col1): latency from start of column-1 dwell.
    pressed[9] = 1'b1;
    wait_col(4'b1101, "reach_col1");
    n = 0;
    while (key_valid !== 1'b1 && n < 40) begin cyc(); n++; end
    chk("press_latency", n, 12);
    chk("key9_code", int'(key_code), 9);
    chk("key9_down", int'(key_down), 1);
    repeat (5) cyc();
    chk("key9_hold_valid", int'(key_valid), 1);
    chk("key9_hold_code", int'(key_code), 9);
    sb.push_back(9);
    pulse_ready();
    chk("key9_ack", int'(key_valid), 0);
    pressed = '0;
    wait_down(1'b0, "key9_release");
    chk("resume_col2", int'(col_drive), 'hB);

    // Single-sample bounce on row0/col3.
    wait_col(4'b0111, "reach_col3");
    pressed[3] = 1'b1;
    repeat (4) cyc();
    pressed[3] = 1'b0;
    n = 0;
    while (col_drive === 4'b0111 && n < 20) begin cyc(); n++; end
    chk("bounce_dwell", n, 4);
    chk("bounce_col", int'(col_drive), 'hE);
    chk("bounce_valid", int'(key_valid), 0);
    chk("bounce_down", int'(key_down), 0);

    // Event coinciding with acceptance: new code wins, no overrun.
    pressed[9] = 1'b1;
    wait_valid("key9b_valid");
    chk("key9b_code", int'(key_code), 9);
    pressed = '0;
    wait_down(1'b0, "key9b_release");
    pressed[14] = 1'b1;
    repeat (11) cyc();
    sb.push_back(9);
    key_ready = 1'b1;
    cyc();
    key_ready = 1'b0;
    chk("simul_valid", int'(key_valid), 1);
    chk("simul_code", int'(key_code), 'hE);
    chk("simul_ovr", int'(overrun), 0);

    // Overwrite of a pending event sets overrun.
    pressed = '0;
    wait_down(1'b0, "key14_release");
    pressed[15] = 1'b1;
    n = 0;
    while (key_code !== 4'hF && n < 100) begin cyc(); n++; end
    chk("ovr_code", int'(key_code), 'hF);
    chk("ovr_valid", int'(key_valid), 1);
    chk("ovr_flag", int'(overrun), 1);
    sb.push_back(15);
    pulse_ready();
    chk("ovr_ack", int'(key_valid), 0);
    pressed = '0;
    wait_down(1'b0, "key15_release");

    // Two rows low on column 0: lowest row wins.
    pressed[4] = 1'b1; pressed[12] = 1'b1;
    wait_valid("two_row_valid");
    chk("two_row_code", int'(key_code), 4);
    sb.push_back(4);
    pulse_ready();
    pressed = '0;
    wait_down(1'b0, "two_row_release");

    // Reset while held, then disable while held.
    pressed[9] = 1'b1;
    wait_down(1'b1, "held_for_reset");
    reset = 1'b1;
    cyc();
    chk("rh_down", int'(key_down), 0);
    chk("rh_valid", int'(key_valid), 0);
    chk("rh_col", int'(col_drive), 'hF);
    chk("rh_ovr", int'(overrun), 0);
    chk("rh_code", int'(key_code), 0);
    reset = 1'b0;
    wait_down(1'b1, "held_for_disable");
    chk("dis_pre_valid", int'(key_valid), 1);
    enable = 1'b0;
    #1;
    chk("dis_col", int'(col_drive), 'hF);
    cyc();
    chk("dis_down", int'(key_down), 0);
    chk("dis_valid", int'(key_valid), 1);
    chk("dis_code", int'(key_code), 9);
    sb.push_back(9);
    pulse_ready();
    chk("dis_ack", int'(key_valid), 0);
    pressed = '0;
    enable = 1'b1;
    #1;
    n = 0;
    while (col_drive === 4'b1110 && n < 20) begin n++; cyc(); end
    chk("reen_dwell", n, 4);

    // Randomized single-column presses with a randomly ready consumer.
    rnd_rdy = 1'b1;
    for (int t = 0; t < 24; t++) begin
      col = $urandom_range(0, 3);
      mask = $urandom_range(1, 15);
      lr = 0;
      pressed = '0;
      for (int r = 3; r >= 0; r--)
        if (mask[r]) begin pressed[r*4+col] = 1'b1; lr = r; end
      sb.push_back(lr * 4 + col);
      wait_down(1'b1, "rnd_press");
      repeat ($urandom_range(0, 10)) cyc();
      pressed = '0;
      wait_down(1'b0, "rnd_release");
      n = 0;
      while (sb.size() != 0 && n < 100) begin cyc(); n++; end
      chk("rnd_drain", sb.size(), 0);
    end
    rnd_rdy = 1'b0;
    key_ready = 1'b0;
    repeat (3) cyc();
    chk("sb_left", sb.size(), 0);
    chk("final_ovr", int'(overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
